// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared read-mode type and sizing helper for the sync FIFO slice
// Purpose: types and helpers common to param_sync_fifo, its interface and its bench.
// Ports: none (package).
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,   // registered read, data one cycle after pop
      FIFO_FWFT = 1'b1    // first-word-fall-through, head word shown while rd_valid
   } fifo_mode_e;

   // Width needed to hold a word count in the range 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// rtl/param_sync_fifo_if.sv - handshake/status bundle between a FIFO user and param_sync_fifo
// Purpose: groups the request, data and status signals of one FIFO.
// Ports (master = user side, slave = FIFO side):
//   flush, push, wr_data, pop           master -> slave
//   rd_data, rd_valid                   slave -> master
//   fifo_full, fifo_empty               slave -> master
//   almost_full, almost_empty, count    slave -> master
//   overflow, underflow                 slave -> master (sticky)
interface param_sync_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
);
   import fifo_pkg::*;

   localparam int CW = cnt_width(FIFO_DEPTH);

   logic                  flush;
   logic                  push;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  pop;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, push, wr_data, pop,
      input  rd_data, rd_valid, fifo_full, fifo_empty,
      input  almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, push, wr_data, pop,
      output rd_data, rd_valid, fifo_full, fifo_empty,
      output almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/simple_dualport_mem.sv
// rtl/simple_dualport_mem.sv - one-write one-read storage array with registered read
// Purpose: FIFO word storage; read data appears one clock after rd_en.
// Ports:
//   clk, reset          clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr       read request; rd_data updates on the next edge, else holds
module simple_dualport_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Array itself carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parameterised single-clock FIFO, standard or FWFT read mode
// Purpose: buffers DATA_WIDTH words, FIFO_DEPTH deep, with capacity/threshold flags
//          and sticky overflow/underflow reporting.
// Ports:
//   clk     clock, all state changes on rising edge
//   reset   asynchronous active-high reset
//   bus     param_sync_fifo_if slave: flush/push/wr_data/pop in;
//           rd_data/rd_valid/fifo_full/fifo_empty/almost_full/almost_empty/
//           count/overflow/underflow out
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int         DATA_WIDTH      = 32,
   parameter int         FIFO_DEPTH      = 16,
   parameter int         ALMOST_FULL_TH  = 12,
   parameter int         ALMOST_EMPTY_TH = 4,
   parameter fifo_mode_e MODE            = FIFO_STD
) (
   input logic              clk,
   input logic              reset,
   param_sync_fifo_if.slave bus
);

   localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int            CW       = cnt_width(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(ALMOST_FULL_TH);
   localparam logic [CW-1:0] AE_C     = CW'(ALMOST_EMPTY_TH);
   localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("param_sync_fifo: DATA_WIDTH must be >= 1");
   end
   if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("param_sync_fifo: FIFO_DEPTH must be >= 2");
   end
   if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_bad_af
      $error("param_sync_fifo: ALMOST_FULL_TH must be in 1..FIFO_DEPTH");
   end
   if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > FIFO_DEPTH - 1) begin : g_bad_ae
      $error("param_sync_fifo: ALMOST_EMPTY_TH must be in 0..FIFO_DEPTH-1");
   end

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  ovf_q;
   logic                  unf_q;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Pointers wrap at FIFO_DEPTH-1 so non-power-of-two depths use every entry.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full = (count_q == DEPTH_C);
   assign wr_acc    = bus.push && !fifo_full  && !bus.flush;
   assign rd_acc    = bus.pop  && !fifo_empty && !bus.flush;

   // rd_ptr follows memory reads, which in FWFT mode run ahead of user pops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (mem_rd_en) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (wr_acc && !rd_acc) begin
            count_q <= count_q + 1'b1;
         end else if (!wr_acc && rd_acc) begin
            count_q <= count_q - 1'b1;
         end
         if (bus.push && fifo_full) begin
            ovf_q <= 1'b1;
         end
         if (bus.pop && fifo_empty) begin
            unf_q <= 1'b1;
         end
      end
   end

   simple_dualport_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (AW)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (bus.wr_data),
      .rd_en   (mem_rd_en),
      .rd_addr (rd_ptr),
      .rd_data (mem_rdata)
   );

   if (MODE == FIFO_FWFT) begin : g_fwft
      // Two-stage prefetch: memory read register (mid) feeds the output register.
      // count covers words in memory, mid and output alike.
      logic                  mid_valid;
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_data;
      logic [CW-1:0]         mem_cnt;
      logic                  advance;

      assign mem_cnt    = count_q - CW'(mid_valid) - CW'(out_valid);
      assign advance    = mid_valid && (!out_valid || rd_acc);
      assign mem_rd_en  = !bus.flush && (mem_cnt != '0) && (!mid_valid || advance);
      assign fifo_empty = !out_valid;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mid_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
         end else if (bus.flush) begin
            mid_valid <= 1'b0;
            out_valid <= 1'b0;
         end else begin
            if (mem_rd_en) begin
               mid_valid <= 1'b1;
            end else if (advance) begin
               mid_valid <= 1'b0;
            end
            if (!out_valid || rd_acc) begin
               out_valid <= mid_valid;
               if (mid_valid) begin
                  out_data <= mem_rdata;
               end
            end
         end
      end

      assign bus.rd_data  = out_data;
      assign bus.rd_valid = out_valid;
   end else begin : g_std
      logic rd_valid_q;

      assign mem_rd_en  = rd_acc;
      assign fifo_empty = (count_q == '0);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
         end
      end

      assign bus.rd_data  = mem_rdata;
      assign bus.rd_valid = rd_valid_q;
   end

   assign bus.fifo_full    = fifo_full;
   assign bus.fifo_empty   = fifo_empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench for param_sync_fifo in STD and FWFT modes
module tb_param_sync_fifo;
   import fifo_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 5;
   localparam int AF    = 4;
   localparam int AE    = 1;

   logic clk;
   logic reset;

   int tests_run;
   int tests_failed;

   logic [DW-1:0] q_a[$];
   logic [DW-1:0] q_b[$];
   int            cnt_a;
   int            cnt_b;
   logic [DW-1:0] last_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   param_sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) a_if ();
   param_sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) b_if ();

   param_sync_fifo #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_TH(AF),
      .ALMOST_EMPTY_TH(AE), .MODE(FIFO_STD)
   ) dut_std (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   param_sync_fifo #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_TH(AF),
      .ALMOST_EMPTY_TH(AE), .MODE(FIFO_FWFT)
   ) dut_fwft (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_a(input string tag);
      check_eq({tag, "_count"},    a_if.count, 0);
      check_eq({tag, "_rd_data"},  a_if.rd_data, 0);
      check_eq({tag, "_rd_valid"}, a_if.rd_valid, 0);
      check_eq({tag, "_empty"},    a_if.fifo_empty, 1);
      check_eq({tag, "_full"},     a_if.fifo_full, 0);
      check_eq({tag, "_aempty"},   a_if.almost_empty, 1);
      check_eq({tag, "_afull"},    a_if.almost_full, 0);
      check_eq({tag, "_ovf"},      a_if.overflow, 0);
      check_eq({tag, "_unf"},      a_if.underflow, 0);
   endtask

   // One STD clock: expected pop word comes off the scoreboard, compared the cycle after.
   task automatic cyc_a(input logic ps, input logic pp, input logic [DW-1:0] d);
      logic          rd_exp;
      logic          wr_exp;
      logic [DW-1:0] exp_word;
      rd_exp   = pp && (cnt_a != 0);
      wr_exp   = ps && (cnt_a < DEPTH);
      exp_word = last_a;
      if (rd_exp) begin
         exp_word = q_a.pop_front();
         cnt_a--;
      end
      if (wr_exp) begin
         q_a.push_back(d);
         cnt_a++;
      end
      a_if.push    = ps;
      a_if.pop     = pp;
      a_if.wr_data = d;
      @(posedge clk);
      #1;
      a_if.push = 1'b0;
      a_if.pop  = 1'b0;
      check_eq("a_rd_valid", a_if.rd_valid, rd_exp);
      check_eq("a_rd_data", a_if.rd_data, exp_word);
      check_eq("a_count", a_if.count, cnt_a);
      last_a = exp_word;
   endtask

   // One FWFT clock: a pop checks the head word against the scoreboard before the edge.
   task automatic cyc_b(input logic ps, input logic pp, input logic [DW-1:0] d);
      logic [DW-1:0] exp_word;
      if (pp) begin
         exp_word = (q_b.size() != 0) ? q_b.pop_front() : '0;
         check_eq("b_head_valid", b_if.rd_valid, 1);
         check_eq("b_head_data", b_if.rd_data, exp_word);
         cnt_b--;
      end
      if (ps && (cnt_b < DEPTH)) begin
         q_b.push_back(d);
         cnt_b++;
      end
      b_if.push    = ps;
      b_if.pop     = pp;
      b_if.wr_data = d;
      @(posedge clk);
      #1;
      b_if.push = 1'b0;
      b_if.pop  = 1'b0;
      check_eq("b_count", b_if.count, cnt_b);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      cnt_a        = 0;
      cnt_b        = 0;
      last_a       = '0;
      reset        = 1'b0;
      a_if.flush = 1'b0; a_if.push = 1'b0; a_if.pop = 1'b0; a_if.wr_data = '0;
      b_if.flush = 1'b0; b_if.push = 1'b0; b_if.pop = 1'b0; b_if.wr_data = '0;
      #1 reset = 1'b1;
      #1;
      check_reset_a("rst");
      check_eq("rst_b_rd_valid", b_if.rd_valid, 0);
      check_eq("rst_b_empty", b_if.fifo_empty, 1);
      check_eq("rst_b_rd_data", b_if.rd_data, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Fill to full, overflow, drain in order.
      for (int i = 0; i < DEPTH; i++) cyc_a(1'b1, 1'b0, DW'(8'hA0 + i));
      check_eq("a_full_at5", a_if.fifo_full, 1);
      cyc_a(1'b1, 1'b0, 8'hFF);
      check_eq("a_overflow", a_if.overflow, 1);
      check_eq("a_full_after_ovf", a_if.fifo_full, 1);
      for (int i = 0; i < DEPTH; i++) cyc_a(1'b0, 1'b1, '0);
      check_eq("a_empty_drained", a_if.fifo_empty, 1);
      check_eq("a_overflow_sticky", a_if.overflow, 1);

      // Pop on empty, then flush clears the sticky flags and keeps rd_data.
      cyc_a(1'b0, 1'b1, '0);
      check_eq("a_underflow", a_if.underflow, 1);
      a_if.flush = 1'b1;
      a_if.push  = 1'b1;
      a_if.wr_data = 8'h77;
      @(posedge clk);
      #1;
      a_if.flush = 1'b0;
      a_if.push  = 1'b0;
      check_eq("a_flush_count", a_if.count, 0);
      check_eq("a_flush_unf", a_if.underflow, 0);
      check_eq("a_flush_ovf", a_if.overflow, 0);
      check_eq("a_flush_rd_valid", a_if.rd_valid, 0);
      check_eq("a_flush_rd_data", a_if.rd_data, last_a);

      // Threshold flags through the whole fill range.
      check_eq("a_aempty_c0", a_if.almost_empty, 1);
      check_eq("a_afull_c0", a_if.almost_full, 0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc_a(1'b1, 1'b0, DW'(8'hD0 + i));
         check_eq("a_almost_empty", a_if.almost_empty, (cnt_a <= AE));
         check_eq("a_almost_full", a_if.almost_full, (cnt_a >= AF));
      end

      // Down to two words, then sustained push+pop across the pointer wrap.
      for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b1, '0);
      for (int i = 0; i < 12; i++) cyc_a(1'b1, 1'b1, DW'(8'hB0 + i));
      for (int i = 0; i < 2; i++) cyc_a(1'b0, 1'b1, '0);
      check_eq("a_empty_after_wrap", a_if.fifo_empty, 1);

      // Reset between edges with three words stored.
      for (int i = 0; i < 3; i++) cyc_a(1'b1, 1'b0, DW'(8'hC0 + i));
      #3 reset = 1'b1;
      #1;
      check_reset_a("midrst");
      q_a.delete();
      q_b.delete();
      cnt_a  = 0;
      cnt_b  = 0;
      last_a = '0;
      #2 reset = 1'b0;
      cyc_a(1'b1, 1'b0, 8'h55);
      cyc_a(1'b0, 1'b1, '0);
      check_eq("a_post_rst_data", a_if.rd_data, 8'h55);

      // FWFT: first word shows exactly two edges after the push.
      cyc_b(1'b1, 1'b0, 8'h11);
      check_eq("b_lat_p1_valid", b_if.rd_valid, 0);
      check_eq("b_lat_p1_empty", b_if.fifo_empty, 1);
      cyc_b(1'b0, 1'b0, '0);
      check_eq("b_lat_p2_valid", b_if.rd_valid, 0);
      cyc_b(1'b0, 1'b0, '0);
      check_eq("b_lat_p3_valid", b_if.rd_valid, 1);
      check_eq("b_lat_p3_data", b_if.rd_data, 8'h11);
      cyc_b(1'b1, 1'b0, 8'h22);
      cyc_b(1'b1, 1'b0, 8'h33);
      for (int i = 0; i < 3; i++) cyc_b(1'b0, 1'b1, '0);
      check_eq("b_drained_valid", b_if.rd_valid, 0);
      check_eq("b_drained_empty", b_if.fifo_empty, 1);

      // FWFT back-to-back pops from a full FIFO.
      for (int i = 0; i < DEPTH; i++) cyc_b(1'b1, 1'b0, DW'(8'hF0 + i));
      check_eq("b_full", b_if.fifo_full, 1);
      cyc_b(1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) cyc_b(1'b0, 1'b1, '0);
      check_eq("b_stream_end_valid", b_if.rd_valid, 0);

      // FWFT simultaneous push and pop at count 1.
      cyc_b(1'b1, 1'b0, 8'hE0);
      cyc_b(1'b0, 1'b0, '0);
      cyc_b(1'b0, 1'b0, '0);
      cyc_b(1'b1, 1'b1, 8'hE1);
      cyc_b(1'b0, 1'b0, '0);
      cyc_b(1'b0, 1'b0, '0);
      cyc_b(1'b0, 1'b1, '0);
      check_eq("b_c1_end_valid", b_if.rd_valid, 0);

      // FWFT underflow, then flush with words in flight leaves nothing stale.
      b_if.pop = 1'b1;
      @(posedge clk);
      #1;
      b_if.pop = 1'b0;
      check_eq("b_underflow", b_if.underflow, 1);
      check_eq("b_unf_count", b_if.count, 0);
      check_eq("b_unf_valid", b_if.rd_valid, 0);
      cyc_b(1'b1, 1'b0, 8'h61);
      cyc_b(1'b1, 1'b0, 8'h62);
      b_if.flush = 1'b1;
      @(posedge clk);
      #1;
      b_if.flush = 1'b0;
      q_b.delete();
      cnt_b = 0;
      check_eq("b_flush_unf", b_if.underflow, 0);
      check_eq("b_flush_count", b_if.count, 0);
      check_eq("b_flush_valid", b_if.rd_valid, 0);
      cyc_b(1'b1, 1'b0, 8'h70);
      cyc_b(1'b0, 1'b0, '0);
      cyc_b(1'b0, 1'b0, '0);
      cyc_b(1'b0, 1'b1, '0);
      check_eq("b_post_flush_empty", b_if.fifo_empty, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
